// File: rtl/reset_sequencer.sv
// Ordered release of memory, register-file and core resets after a held reset.
// Optional watchdog (macro WATCHDOG_EN) replays the sequence when RUN is not kicked.
module reset_sequencer #(
  parameter int HOLD_CYCLES = 8,
  parameter int STAGE_DELAY = 16,
  parameter int CNT_W       = 8,
  parameter int WDT_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic soft_req,
  output logic soft_ack,
  output logic rst_mem,
  output logic rst_regs,
  output logic rst_core,
  output logic ready
`ifdef WATCHDOG_EN
  ,
  input  logic wdt_kick,
  output logic wdt_fired
`endif
);

  typedef enum logic [1:0] {
    S_HOLD   = 2'd0,
    S_STAGE1 = 2'd1,
    S_STAGE2 = 2'd2,
    S_RUN    = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DELAY - 1);

  // A counter that cannot reach the terminal count would never release the resets.
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > (2 ** CNT_W) ||
      STAGE_DELAY < 1 || STAGE_DELAY > (2 ** CNT_W) ||
      WDT_TIMEOUT < 1 || WDT_TIMEOUT > 65536) begin : g_bad_cfg
    $error("reset_sequencer: parameter out of range for counter width");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rst_mem_q, rst_mem_d;
  logic             rst_regs_q, rst_regs_d;
  logic             rst_core_q, rst_core_d;
  logic             ready_q, ready_d;
  logic             soft_ack_q, soft_ack_d;
  logic             restart;

`ifdef WATCHDOG_EN
  localparam logic [15:0] WDT_LAST = 16'(WDT_TIMEOUT - 1);

  logic [15:0] wdt_cnt_q, wdt_cnt_d;
  logic        wdt_fired_q, wdt_fired_d;
  logic        wdt_timeout;

  assign wdt_timeout = (state_q == S_RUN) && !wdt_kick && (wdt_cnt_q == WDT_LAST);
`else
  logic wdt_timeout;

  assign wdt_timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rst_mem_d  = 1'b1;
    rst_regs_d = 1'b1;
    rst_core_d = 1'b1;
    ready_d    = 1'b0;
    soft_ack_d = 1'b0;
    restart    = 1'b0;

    case (state_q)
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d   = S_STAGE1;
          rst_mem_d = 1'b0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STAGE1: begin
        rst_mem_d = 1'b0;
        if (cnt_q == STAGE_LAST) begin
          state_d    = S_STAGE2;
          rst_regs_d = 1'b0;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STAGE2: begin
        rst_mem_d  = 1'b0;
        rst_regs_d = 1'b0;
        if (cnt_q == STAGE_LAST) begin
          state_d    = S_RUN;
          rst_core_d = 1'b0;
          ready_d    = 1'b1;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        rst_mem_d  = 1'b0;
        rst_regs_d = 1'b0;
        rst_core_d = 1'b0;
        ready_d    = 1'b1;
        cnt_d      = '0;
        // A software request takes priority over a coincident watchdog timeout.
        if (soft_req) begin
          restart    = 1'b1;
          soft_ack_d = 1'b1;
        end else if (wdt_timeout) begin
          restart = 1'b1;
        end
        if (restart) begin
          state_d    = S_HOLD;
          rst_mem_d  = 1'b1;
          rst_regs_d = 1'b1;
          rst_core_d = 1'b1;
          ready_d    = 1'b0;
        end
      end
      default: begin
        state_d = S_HOLD;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef WATCHDOG_EN
  always_comb begin
    wdt_cnt_d   = '0;
    wdt_fired_d = wdt_fired_q;
    if (state_q == S_RUN && !restart) begin
      wdt_cnt_d = wdt_kick ? 16'd0 : wdt_cnt_q + 16'd1;
    end
    if (wdt_timeout && !soft_req) begin
      wdt_fired_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wdt_cnt_q   <= '0;
      wdt_fired_q <= 1'b0;
    end else begin
      wdt_cnt_q   <= wdt_cnt_d;
      wdt_fired_q <= wdt_fired_d;
    end
  end

  assign wdt_fired = wdt_fired_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_HOLD;
      cnt_q      <= '0;
      rst_mem_q  <= 1'b1;
      rst_regs_q <= 1'b1;
      rst_core_q <= 1'b1;
      ready_q    <= 1'b0;
      soft_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rst_mem_q  <= rst_mem_d;
      rst_regs_q <= rst_regs_d;
      rst_core_q <= rst_core_d;
      ready_q    <= ready_d;
      soft_ack_q <= soft_ack_d;
    end
  end

  assign soft_ack = soft_ack_q;
  assign rst_mem  = rst_mem_q;
  assign rst_regs = rst_regs_q;
  assign rst_core = rst_core_q;
  assign ready    = ready_q;

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Consumes the single synchronised core reset and releases the CPU subsystem resets in a fixed order: memory first, then the register file, then the core pipeline. Each release is separated by a programmable delay. The block also accepts a software reset request from the CPU and replays the full sequence. It sits directly downstream of the power-on/async-reset conditioning logic and drives the reset inputs of the memory, register file and core.

Parameters:
HOLD_CYCLES, 8, cycles all resets stay asserted after entering HOLD (1..256)
STAGE_DELAY, 16, cycles between successive stage releases (1..256)
CNT_W, 8, width of the internal sequencing counter
WDT_TIMEOUT, 1024, watchdog timeout in cycles (used only with WATCHDOG_EN, 1..2^16)

Ports:
clk        in   1  system clock; all logic on its rising edge
reset      in   1  synchronous, active-high reset
soft_req   in   1  software reset request, level-sampled in RUN only
soft_ack   out  1  one-cycle pulse: soft request accepted
rst_mem    out  1  memory reset, active-high
rst_regs   out  1  register file reset, active-high
rst_core   out  1  core pipeline reset, active-high
ready      out  1  high when all stage resets are released
wdt_kick   in   1  watchdog kick (present only with WATCHDOG_EN)
wdt_fired  out  1  sticky watchdog-timeout flag (present only with WATCHDOG_EN)

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high. Every output is registered.
- On any edge where reset=1:
  - state <= HOLD, cnt <= 0.
  - rst_mem = rst_regs = rst_core = 1.
  - ready = 0, soft_ack = 0.
  - Reset asserted mid-sequence or in RUN restarts the sequence from HOLD.
- States: HOLD -> STAGE1 -> STAGE2 -> RUN, plus RUN -> HOLD on a software request. Encodings outside these four go to HOLD with all resets asserted.
- HOLD:
  - All three resets high.
  - At each edge: if cnt == HOLD_CYCLES-1, go to STAGE1, rst_mem <= 0, cnt <= 0; otherwise cnt++.
  - rst_mem therefore falls on the HOLD_CYCLES-th edge after entry.
- STAGE1:
  - rst_mem low; rst_regs and rst_core high.
  - When cnt == STAGE_DELAY-1: go to STAGE2, rst_regs <= 0, cnt <= 0; otherwise cnt++.
- STAGE2:
  - When cnt == STAGE_DELAY-1: go to RUN, rst_core <= 0, ready <= 1, cnt <= 0; otherwise cnt++.
- RUN:
  - All resets low, ready = 1.
  - If soft_req = 1 at an edge: state <= HOLD, cnt <= 0, all resets <= 1, ready <= 0, soft_ack <= 1 for exactly that one cycle.
- soft_req outside RUN is ignored: no ack, and sequence timing is unchanged.
- soft_req held high continuously re-triggers on every entry to RUN, producing one ack per full sequence.
- Counter never wraps. Parameter values above 2^CNT_W are a configuration error, flagged by a simulation-time check.
- Release order is fixed and guaranteed: rst_mem falls strictly before rst_regs, which falls strictly before rst_core.

Optional Feature:
WATCHDOG_EN
- Defined:
  - A 16-bit watchdog counter runs only in RUN.
  - wdt_kick = 1 clears the counter; otherwise it increments.
  - On reaching WDT_TIMEOUT-1 without a kick, the block takes the same transition as a soft request, except soft_ack stays 0.
  - wdt_fired <= 1 on that edge. It stays set until reset=1; soft resets do not clear it.
  - The watchdog counter is cleared on reset and whenever the state is not RUN.
  - If soft_req and the timeout coincide on the same edge, soft_req wins: soft_ack = 1, wdt_fired is unchanged.
- Undefined: wdt_kick and wdt_fired ports are absent, with no watchdog logic.

Test Plan:
1. HOLD_CYCLES=4, STAGE_DELAY=3; reset high 5 cycles, low from edge 0 -> rst_mem falls on edge 4, rst_regs on edge 7, rst_core and ready on edge 10; all outputs were 1/1/1/0 during reset.
2. Same params, in RUN pulse soft_req for 1 cycle at edge A -> soft_ack=1 for exactly cycle A only; resets 1 and ready 0 from A; rst_mem falls at A+4, rst_regs at A+7, rst_core and ready at A+10.
3. soft_req held high during STAGE1 and STAGE2, dropped before RUN -> soft_ack never asserts; release edges identical to scenario 1.
4. reset asserted for 1 cycle during STAGE2 (edge 8) -> all resets 1 and ready 0 at edge 8; rst_mem falls 4 edges after reset drops, full sequence restarts.
5. soft_req tied high from RUN entry -> soft_ack pulses every 11 cycles; ready high for exactly 1 cycle per period.
6. WATCHDOG_EN, WDT_TIMEOUT=20, no kicks in RUN -> 20 cycles after RUN entry, all resets reassert and wdt_fired=1 with soft_ack=0; with a kick every 10 cycles there is no timeout over 500 cycles.
